postprocess_ctrl: RTL and testbench
===================================

POSTPROCESS_CTRL -- requirements
Module: postprocess_ctrl

Interface
REQ-001 Parameter POX, default 3, output pixels per data beat.
REQ-002 Parameter ADDR_W, default 16, output-buffer address width.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 start  input  1  one-cycle pulse; accepted only in IDLE.
REQ-006 cfg_num_ch  input  16  output channels per layer; 0 is legal.
REQ-007 cfg_groups  input  16  POX-wide beats per channel; 0 is treated as 1.
REQ-008 param_rd_en  output  1  parameter-RAM read strobe.
REQ-009 param_addr  output  16  parameter-RAM address; equals channel index.
REQ-010 param_rd_data  input  48  {bias[47:32], K[31:16], B[15:0]}; valid exactly 1 cycle after param_rd_en.
REQ-011 in_valid  input  1  upstream accumulator beat available.
REQ-012 in_ready  output  1  controller accepts beat; transfer = in_valid & in_ready.
REQ-013 pp_valid  output  1  drives datapath input-valid; combinationally equals transfer.
REQ-014 pp_bias, pp_k, pp_b  output  16 each  registered per-channel parameters to datapath.
REQ-015 pp_out_valid  input  1  datapath final-stage valid (2 cycles after pp_valid).
REQ-016 wr_en  output  1  equals pp_out_valid.
REQ-017 wr_addr  output  ADDR_W  output-buffer beat address for current wr_en.
REQ-018 busy  output  1  high in any state except IDLE.
REQ-019 done  output  1  one-cycle pulse at layer completion.

Function
REQ-020 States: IDLE, LOAD, LWAIT, RUN, DRAIN, FIN.
REQ-021 IDLE: on start, latch cfg_*, clear ch_cnt, grp_cnt, wr_addr; go LOAD, or FIN if cfg_num_ch==0.
REQ-022 LOAD: param_rd_en=1, param_addr=ch_cnt for one cycle; go LWAIT.
REQ-023 LWAIT: capture param_rd_data into pp_bias/pp_k/pp_b; go RUN.
REQ-024 RUN: in_ready=1; each transfer increments grp_cnt; transfer with grp_cnt==groups-1 clears grp_cnt and goes DRAIN.
REQ-025 in_ready=0 in all states except RUN; no beat accepted outside RUN.
REQ-026 DRAIN: hold parameters 2 cycles (datapath latency) so the last beat finishes with its channel's parameters; then ch_cnt+1, go LOAD, or FIN if ch_cnt==num_ch-1.
REQ-027 Parameter registers change only in LWAIT; constant from LWAIT exit to next LWAIT.
REQ-028 wr_addr increments by 1 after every wr_en cycle, wrapping at 2^ADDR_W; counts independently of state.
REQ-029 FIN: wait until outstanding-beat counter (plus on pp_valid, minus on pp_out_valid, simultaneous = unchanged) is 0; pulse done 1 cycle; go IDLE.
REQ-030 Channel switch minimum cost: 4 idle cycles (DRAIN 2 + LOAD + LWAIT) between last beat of ch N and first beat of ch N+1.
REQ-031 start while busy ignored; cfg_* changes while busy ignored.
REQ-032 Upstream may hold in_valid through non-RUN states; no beat lost or duplicated.

Reset
REQ-033 rst asserted: state=IDLE; in_ready, param_rd_en, done, busy=0; param_addr, pp_bias, pp_k, pp_b, wr_addr, all counters=0.
REQ-034 rst mid-layer aborts immediately; no done pulse; next start begins fresh layer.

Structure
REQ-035 Shared package: state encoding enum, PP_LATENCY=2, PARAM_W=48 with field offsets.
REQ-036 Instantiates no datapath; top level connects it to the 2-stage post-process datapath. One sub-module natural: pp_param_reg (LWAIT-enabled 3x16 parameter register).

Verification
REQ-037 num_ch=2, groups=3, in_valid always 1, RAM {0x0010,0x0800,0x0000},{0x0020,0x1000,0x0001}: 6 transfers, 4-cycle gap between channels, wr_addr 0..5, done once.
REQ-038 num_ch=0, start -> done one cycle later, no param_rd_en, no in_ready.
REQ-039 groups=4, in_valid toggled randomly -> exactly 4 transfers/channel, params stable across stalls.
REQ-040 rst pulsed during RUN of ch 1 -> all outputs at reset values same cycle; restart completes normally.
REQ-041 start pulsed during RUN -> ignored, ch_cnt/grp_cnt undisturbed, single done.
REQ-042 ADDR_W=2, 6 beats -> wr_addr 0,1,2,3,0,1.

Source files
------------

// File: rtl/postprocess_ctrl_pkg.sv
// Shared definitions for the post-process controller: FSM encoding, datapath
// latency and the parameter-RAM word layout.
package postprocess_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    LWAIT = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4,
    FIN   = 3'd5
  } state_t;

  localparam int PP_LATENCY = 2;
  localparam logic [1:0] DRAIN_LAST = 2'(PP_LATENCY - 1);

  localparam int PARAM_W  = 48;
  localparam int FIELD_W  = 16;
  localparam int BIAS_LSB = 32;
  localparam int K_LSB    = 16;
  localparam int B_LSB    = 0;

  function automatic logic [FIELD_W-1:0] param_bias(input logic [PARAM_W-1:0] word);
    return word[BIAS_LSB +: FIELD_W];
  endfunction

  function automatic logic [FIELD_W-1:0] param_k(input logic [PARAM_W-1:0] word);
    return word[K_LSB +: FIELD_W];
  endfunction

  function automatic logic [FIELD_W-1:0] param_b(input logic [PARAM_W-1:0] word);
    return word[B_LSB +: FIELD_W];
  endfunction

endpackage

// File: rtl/postprocess_ctrl_pp_param_reg.sv
// Per-channel parameter holding register; loads only while the controller
// sits in LWAIT so the datapath sees constant parameters for a whole channel.
module pp_param_reg
  import postprocess_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [PARAM_W-1:0] rd_data,
  output logic [FIELD_W-1:0] bias,
  output logic [FIELD_W-1:0] k,
  output logic [FIELD_W-1:0] b
);

  // Capture the three fields of the parameter word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bias <= 16'd0;
      k    <= 16'd0;
      b    <= 16'd0;
    end else if (load) begin
      bias <= param_bias(rd_data);
      k    <= param_k(rd_data);
      b    <= param_b(rd_data);
    end
  end

endmodule

// File: rtl/postprocess_ctrl.sv
// Layer sequencer for the post-process stage: fetches per-channel parameters,
// meters accumulator beats into the datapath and addresses the output buffer.
module postprocess_ctrl
  import postprocess_ctrl_pkg::*;
#(
  parameter int POX    = 3,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       cfg_num_ch,
  input  logic [15:0]       cfg_groups,
  output logic              param_rd_en,
  output logic [15:0]       param_addr,
  input  logic [47:0]       param_rd_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              pp_valid,
  output logic [15:0]       pp_bias,
  output logic [15:0]       pp_k,
  output logic [15:0]       pp_b,
  input  logic              pp_out_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              done
);

  // POX only shapes the external datapath; the controller counts whole beats.
  if (POX < 1) begin : g_pox_unsupported
  end

  state_t      state;
  logic [15:0] num_ch;
  logic [15:0] groups;
  logic [15:0] ch_cnt;
  logic [15:0] grp_cnt;
  logic [1:0]  drain_cnt;
  logic [2:0]  outstanding;
  logic        transfer;

  assign transfer = in_valid & in_ready;
  assign pp_valid = transfer;
  assign wr_en    = pp_out_valid;

  pp_param_reg u_param_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (state == LWAIT),
    .rd_data (param_rd_data),
    .bias    (pp_bias),
    .k       (pp_k),
    .b       (pp_b)
  );

  // Layer sequencing FSM with registered handshake/status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      num_ch      <= 16'd0;
      groups      <= 16'd0;
      ch_cnt      <= 16'd0;
      grp_cnt     <= 16'd0;
      drain_cnt   <= 2'd0;
      param_rd_en <= 1'b0;
      param_addr  <= 16'd0;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done        <= 1'b0;
      param_rd_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            num_ch     <= cfg_num_ch;
            groups     <= (cfg_groups == 16'd0) ? 16'd1 : cfg_groups;
            ch_cnt     <= 16'd0;
            grp_cnt    <= 16'd0;
            drain_cnt  <= 2'd0;
            param_addr <= 16'd0;
            busy       <= 1'b1;
            if (cfg_num_ch == 16'd0) begin
              state <= FIN;
            end else begin
              state       <= LOAD;
              param_rd_en <= 1'b1;
            end
          end
        end
        LOAD: begin
          state <= LWAIT;
        end
        LWAIT: begin
          state    <= RUN;
          in_ready <= 1'b1;
        end
        RUN: begin
          if (transfer) begin
            if (grp_cnt == groups - 16'd1) begin
              grp_cnt  <= 16'd0;
              in_ready <= 1'b0;
              state    <= DRAIN;
            end else begin
              grp_cnt <= grp_cnt + 16'd1;
            end
          end
        end
        DRAIN: begin
          // Hold parameters until the channel's last beat leaves the datapath
          if (drain_cnt == DRAIN_LAST) begin
            drain_cnt <= 2'd0;
            if (ch_cnt == num_ch - 16'd1) begin
              state <= FIN;
            end else begin
              ch_cnt      <= ch_cnt + 16'd1;
              param_addr  <= ch_cnt + 16'd1;
              param_rd_en <= 1'b1;
              state       <= LOAD;
            end
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        FIN: begin
          if (outstanding == 3'd0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          busy      <= 1'b0;
          grp_cnt   <= 16'd0;
          drain_cnt <= 2'd0;
        end
      endcase
    end
  end

  // Beats inside the datapath; FIN waits for this to empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= 3'd0;
    end else begin
      case ({pp_valid, pp_out_valid})
        2'b10:   outstanding <= outstanding + 3'd1;
        2'b01:   outstanding <= outstanding - 3'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Output-buffer address: restarts per layer, then follows every write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr <= '0;
    end else if (state == IDLE && start) begin
      wr_addr <= '0;
    end else if (wr_en) begin
      wr_addr <= wr_addr + 1'b1;
    end
  end

endmodule

// File: tb/tb_postprocess_ctrl.sv
// Scoreboard bench for postprocess_ctrl: tests queue expected output-buffer
// writes; a monitor pops and compares them whenever wr_en is seen.
module tb_postprocess_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] cfg_num_ch = 16'd0;
  logic [15:0] cfg_groups = 16'd0;
  logic [47:0] param_rd_data = 48'd0;
  logic        in_valid = 1'b0;
  logic        pp_out_valid;

  logic        param_rd_en, in_ready, pp_valid, wr_en, busy, done;
  logic [15:0] param_addr, pp_bias, pp_k, pp_b, wr_addr;

  logic        param_rd_en_n, in_ready_n, pp_valid_n, wr_en_n, busy_n, done_n;
  logic [15:0] param_addr_n, pp_bias_n, pp_k_n, pp_b_n;
  logic [1:0]  wr_addr_n;

  postprocess_ctrl #(.POX(3), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_num_ch(cfg_num_ch), .cfg_groups(cfg_groups),
    .param_rd_en(param_rd_en), .param_addr(param_addr), .param_rd_data(param_rd_data),
    .in_valid(in_valid), .in_ready(in_ready), .pp_valid(pp_valid),
    .pp_bias(pp_bias), .pp_k(pp_k), .pp_b(pp_b), .pp_out_valid(pp_out_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .busy(busy), .done(done)
  );

  postprocess_ctrl #(.POX(3), .ADDR_W(2)) dut_narrow (
    .clk(clk), .rst(rst), .start(start), .cfg_num_ch(cfg_num_ch), .cfg_groups(cfg_groups),
    .param_rd_en(param_rd_en_n), .param_addr(param_addr_n), .param_rd_data(param_rd_data),
    .in_valid(in_valid), .in_ready(in_ready_n), .pp_valid(pp_valid_n),
    .pp_bias(pp_bias_n), .pp_k(pp_k_n), .pp_b(pp_b_n), .pp_out_valid(pp_out_valid),
    .wr_en(wr_en_n), .wr_addr(wr_addr_n), .busy(busy_n), .done(done_n)
  );

  always #5 clk = ~clk;

  logic [47:0] ram [0:3];
  logic [1:0]  dly;

  always @(posedge clk) begin
    if (param_rd_en) param_rd_data <= ram[param_addr[1:0]];
  end

  // Stand-in for the 2-stage datapath valid pipeline
  always @(posedge clk or posedge rst) begin
    if (rst) dly <= 2'b00;
    else     dly <= {dly[0], pp_valid};
  end
  assign pp_out_valid = dly[1];

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] bias;
    logic [15:0] k;
    logic [15:0] b;
  } wr_t;

  wr_t exp_q[$];
  int  xfer_cyc[$];
  int  checks = 0, failures = 0;
  int  rd_cnt = 0, done_cnt = 0, xfer_cnt = 0, rdy_cnt = 0, cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_layer(input int nch, input int grp);
    int a = 0;
    for (int c = 0; c < nch; c++) begin
      for (int g = 0; g < grp; g++) begin
        exp_q.push_back({16'(a), ram[c][47:32], ram[c][31:16], ram[c][15:0]});
        a++;
      end
    end
  endtask

  task automatic start_layer(input logic [15:0] nch, input logic [15:0] grp);
    @(posedge clk); #1;
    cfg_num_ch = nch;
    cfg_groups = grp;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_num_ch = 16'hFFFF;
    cfg_groups = 16'hFFFF;
  endtask

  task automatic wait_done(input int target, input string name);
    int k = 0;
    while (done_cnt < target && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    if (done_cnt < target) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: done count %0d expected %0d", name, done_cnt, target);
    end
  endtask

  initial begin
    ram[0] = {16'h0010, 16'h0800, 16'h0000};
    ram[1] = {16'h0020, 16'h1000, 16'h0001};
    ram[2] = {16'h0030, 16'h1800, 16'h0002};
    ram[3] = {16'h0040, 16'h2000, 16'h0003};
    fork
      begin : monitor
        wr_t e;
        forever begin
          @(negedge clk);
          cyc++;
          if (!rst) begin
            if (wr_en) begin
              if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr %0h expected no write", wr_addr);
              end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 64'(wr_addr), 64'(e.addr));
                chk("wr_addr_narrow", 64'(wr_addr_n), 64'(e.addr[1:0]));
                chk("pp_bias", 64'(pp_bias), 64'(e.bias));
                chk("pp_k", 64'(pp_k), 64'(e.k));
                chk("pp_b", 64'(pp_b), 64'(e.b));
              end
            end
            if (pp_valid) begin
              xfer_cnt++;
              xfer_cyc.push_back(cyc);
            end
            if (param_rd_en) rd_cnt++;
            if (done) done_cnt++;
            if (in_ready) rdy_cnt++;
          end
        end
      end
      begin : tests
        int b0, r0, d0, x0, y0, k;
        in_valid = 1'b1;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_rd_en", 64'(param_rd_en), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_param_addr", 64'(param_addr), 64'd0);
        chk("rst_params", {16'd0, pp_bias, pp_k, pp_b}, 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        rst = 1'b0;

        // Two channels, three groups, continuous input
        b0 = xfer_cyc.size(); r0 = rd_cnt; d0 = done_cnt;
        push_layer(2, 3);
        start_layer(16'd2, 16'd3);
        chk("busy_running", 64'(busy), 64'd1);
        wait_done(d0 + 1, "t1");
        repeat (3) @(posedge clk);
        #1;
        chk("t1_xfers", 64'(xfer_cyc.size() - b0), 64'd6);
        if (xfer_cyc.size() - b0 >= 4) begin
          chk("t1_burst", 64'(xfer_cyc[b0 + 2] - xfer_cyc[b0]), 64'd2);
          chk("t1_ch_gap", 64'(xfer_cyc[b0 + 3] - xfer_cyc[b0 + 2]), 64'd5);
        end
        chk("t1_rd_count", 64'(rd_cnt - r0), 64'd2);
        chk("t1_done_count", 64'(done_cnt - d0), 64'd1);
        chk("t1_busy_idle", 64'(busy), 64'd0);
        chk("t1_drained", 64'(exp_q.size()), 64'd0);

        // Zero channels: straight to FIN, done on the next edge
        r0 = rd_cnt; d0 = done_cnt; y0 = rdy_cnt;
        start_layer(16'd0, 16'd3);
        k = 0;
        while (!done && k < 10) begin
          @(posedge clk); #1;
          k++;
        end
        chk("t2_done_latency", 64'(k), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("t2_rd_count", 64'(rd_cnt - r0), 64'd0);
        chk("t2_ready_cycles", 64'(rdy_cnt - y0), 64'd0);
        chk("t2_done_count", 64'(done_cnt - d0), 64'd1);

        // Four groups with randomly stalled input
        x0 = xfer_cnt; d0 = done_cnt;
        push_layer(2, 4);
        start_layer(16'd2, 16'd4);
        k = 0;
        while (done_cnt < d0 + 1 && k < 600) begin
          @(posedge clk); #1;
          in_valid = 1'($urandom_range(0, 1));
          k++;
        end
        if (done_cnt < d0 + 1) begin
          checks++;
          failures++;
          $display("FAIL t3_timeout: done count %0d expected %0d", done_cnt, d0 + 1);
        end
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("t3_xfers", 64'(xfer_cnt - x0), 64'd8);
        chk("t3_drained", 64'(exp_q.size()), 64'd0);

        // Reset during RUN of channel 1, then a fresh layer
        x0 = xfer_cnt; d0 = done_cnt;
        push_layer(1, 3);
        start_layer(16'd2, 16'd3);
        k = 0;
        while (xfer_cnt < x0 + 4 && k < 100) begin
          @(posedge clk); #1;
          k++;
        end
        chk("t4_reached_ch1", 64'(xfer_cnt - x0), 64'd4);
        chk("t4_in_run", 64'(in_ready), 64'd1);
        rst = 1'b1;
        #1;
        chk("t4_in_ready", 64'(in_ready), 64'd0);
        chk("t4_pp_valid", 64'(pp_valid), 64'd0);
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_rd_en", 64'(param_rd_en), 64'd0);
        chk("t4_param_addr", 64'(param_addr), 64'd0);
        chk("t4_params", {16'd0, pp_bias, pp_k, pp_b}, 64'd0);
        chk("t4_wr_addr", 64'(wr_addr), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t4_no_done", 64'(done_cnt - d0), 64'd0);
        chk("t4_aborted_drained", 64'(exp_q.size()), 64'd0);
        push_layer(2, 3);
        start_layer(16'd2, 16'd3);
        wait_done(d0 + 1, "t4");
        repeat (2) @(posedge clk);
        #1;
        chk("t4_restart_drained", 64'(exp_q.size()), 64'd0);

        // Start pulse with new config while running is ignored
        x0 = xfer_cnt; d0 = done_cnt; r0 = rd_cnt;
        push_layer(2, 3);
        start_layer(16'd2, 16'd3);
        k = 0;
        while (xfer_cnt < x0 + 2 && k < 50) begin
          @(posedge clk); #1;
          k++;
        end
        cfg_num_ch = 16'd5;
        cfg_groups = 16'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(d0 + 1, "t5");
        repeat (20) @(posedge clk);
        #1;
        chk("t5_done_count", 64'(done_cnt - d0), 64'd1);
        chk("t5_rd_count", 64'(rd_cnt - r0), 64'd2);
        chk("t5_xfers", 64'(xfer_cnt - x0), 64'd6);
        chk("t5_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    join_any
  end

endmodule
